mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised byte-serial memory controller: replaces the fixed two-client (instruction/data) controller in the RISCV32I core with an `NPORT`-client, round-robin arbiter that serialises 1/2/4-byte reads and writes onto the 8-bit RAM/IO bus. It sits between the caches/LSB and the external `mem_*` pins. Its new capabilities are:
- per-port flush for misprediction recovery;
- IO back-pressure on UART writes;
- a clean `rdy` freeze.

## Interface
Parameters:
- `NPORT`, 2: number of requesting clients (1..8); port 0 is conventionally ICache, port 1 DCache.
- `IO_STALL`, 1: when 1, writes to IO space wait while `io_buffer_full` is high.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  global ready; low freezes all state.
- `req_valid`  in  NPORT  request pending, held until `resp_valid[p]` or `flush[p]`.
- `req_we`  in  NPORT  1 = write, 0 = read.
- `req_size`  in  2*NPORT  0 = byte, 1 = half, 2 or 3 = word.
- `req_addr`  in  32*NPORT  byte address of byte 0.
- `req_wdata`  in  32*NPORT  write data; byte i = bits [8i+7:8i].
- `flush`  in  NPORT  abort/cancel for port p.
- `resp_valid`  out  NPORT  one-cycle completion pulse, one-hot.
- `resp_data`  out  32  read result, zero-extended; valid only when a `resp_valid` bit is high.
- `mem_din`  in  8  RAM/IO read byte (data appears the cycle after its address).
- `mem_dout`  out  8  write byte.
- `mem_a`  out  32  byte address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  UART transmit buffer full.

## Operation
States:
- IDLE
- RD: issue address, capture bytes
- WR: issue bytes
- RDWAIT: last byte capture

Arbitration:
- In IDLE, the eligible ports are those with `req_valid & ~flush`.
- The winner is the first eligible port at or after `ptr`, wrapping modulo `NPORT`.
- On grant: latch we/size/addr/wdata and set `ptr` = winner+1 (wrapping).
- N = 1, 2 or 4 bytes per `req_size`. Byte i address = addr+i, 32-bit wrap.

Reads:
- Drive `mem_a` = addr+i for i = 0..N-1 on consecutive cycles.
- Capture `mem_din` into `resp_data` byte i one cycle after its address.
- Pulse `resp_valid[p]` after the last byte is captured.

Writes:
- Drive `mem_a` = addr+i, `mem_dout` = byte i, `mem_wr` = 1 for i = 0..N-1.
- Pulse `resp_valid[p]` after the last byte.

IO stall:
- Applies when `IO_STALL`=1, the write address has [17:16]=2'b11, and `io_buffer_full`=1 at the edge that would issue the byte.
- That byte is not issued: `mem_wr`=0, `mem_a`=0.
- Retry every cycle until `io_buffer_full` is low.

Flush:
- `flush[p]` on the port currently in a read: abort at the next edge, go to IDLE, no `resp_valid`, `resp_data` unchanged.
- On a write in progress: the write completes (no partial stores) and `resp_valid[p]` still pulses. The client ignores it.
- On a non-granted port: no effect beyond ineligibility that cycle.

`rdy` low:
- All registers hold, including the byte counter and `ptr`.
- `mem_wr` is forced to 0 combinationally.
- `mem_a` holds, so a pending read byte is still valid on resume.

Outside active transfers: `mem_a`=0, `mem_wr`=0, `mem_dout`=0.

## Timing
- Reset values: `mem_a`=0, `mem_dout`=0, `mem_wr`=0, `resp_valid`=0, `resp_data`=0, state IDLE, `ptr`=0.
- All outputs are registered except the `rdy` gating of `mem_wr`.
- Grant edge ends cycle G. `mem_a` = addr+i in cycle G+1+i.

Reads:
- Byte i is on `mem_din` in cycle G+2+i.
- `resp_valid` is high in cycle G+N+2, which gives word 6, half 4, byte 3.

Writes:
- `resp_valid` is high in cycle G+N+1, which gives word 5, byte 2, plus one cycle per IO stall.

Back-to-back and simultaneous events:
- A new grant can occur in the same cycle as `resp_valid`, i.e. the IDLE state is shared with that cycle.
- The requestor must drop or replace `req_valid` in the cycle after `resp_valid`. A still-high `req_valid` in the `resp_valid` cycle is not re-granted to the same port in that cycle.
- `flush` and `resp_valid` in the same cycle: `resp_valid` stands.
- Reset mid-transfer: immediate return to reset values. No further memory activity.

## Test plan
- Reset, then port 0 word read at 0x100 with RAM bytes 13,12,11,10 at 0x100..0x103 -> `mem_a` 0x100..0x103 in cycles 1..4, `resp_valid`=2'b01 in cycle 6, `resp_data`=0x10111213.
- Ports 0 and 1 both request continuously with `ptr`=0 -> grants alternate 0,1,0,1, each `resp_valid` one-hot and one cycle long.
- Port 1 byte write of 0x41 to 0x30000 with `io_buffer_full` high for 3 cycles -> `mem_wr` stays low 3 cycles, then one cycle with `mem_a`=0x30000, `mem_dout`=0x41, then `resp_valid[1]`.
- Port 0 word read with `flush[0]` in cycle 3 -> return to IDLE, no `resp_valid`, a pending port 1 request is granted next cycle.
- Half read with `rdy` low for 2 cycles after the first address -> total latency 6, data correct, `mem_wr` stays 0 throughout.
- Port 1 word write, then `rst` low mid-transfer (cycle 2) -> all outputs 0 asynchronously. After release, no further writes until a new request.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Client request/response and byte-serial memory bus bundle for mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned NPORT = 2
);
  logic [NPORT-1:0]    req_valid;
  logic [NPORT-1:0]    req_we;
  logic [2*NPORT-1:0]  req_size;
  logic [32*NPORT-1:0] req_addr;
  logic [32*NPORT-1:0] req_wdata;
  logic [NPORT-1:0]    flush;
  logic [NPORT-1:0]    resp_valid;
  logic [31:0]         resp_data;
  logic [7:0]          mem_din;
  logic [7:0]          mem_dout;
  logic [31:0]         mem_a;
  logic                mem_wr;
  logic                io_buffer_full;

  // Client/environment side: drives requests and the RAM/IO return path.
  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, flush,
    output mem_din, io_buffer_full,
    input  resp_valid, resp_data, mem_dout, mem_a, mem_wr
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, flush,
    input  mem_din, io_buffer_full,
    output resp_valid, resp_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// NPORT-client round-robin arbiter serialising 1/2/4-byte reads and writes
// onto the 8-bit RAM/IO bus, with per-port flush, IO back-pressure and rdy freeze.
module mem_arbiter #(
  parameter int unsigned NPORT    = 2,
  parameter bit          IO_STALL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);

  localparam int unsigned PW  = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned PW1 = PW + 1;
  localparam int unsigned CW  = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD     = 2'd1,
    S_WR     = 2'd2,
    S_RDWAIT = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_port;
  logic [CW-1:0]   r_n;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rbuf;
  logic [31:0]     r_mem_a;
  logic [7:0]      r_mem_dout;
  logic            r_mem_wr;
  logic [NPORT-1:0] r_resp_valid;
  logic [31:0]     r_resp_data;

  logic [31:0]     w_addr_a  [NPORT];
  logic [31:0]     w_wdata_a [NPORT];
  logic [1:0]      w_size_a  [NPORT];

  logic [NPORT-1:0] w_elig;
  logic            w_gnt;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_ptr_next;
  logic [31:0]     w_win_addr;
  logic [31:0]     w_win_wdata;
  logic            w_win_we;
  logic [CW-1:0]   w_win_n;
  logic            w_stall_gnt;
  logic            w_stall_wr;
  logic [31:0]     w_byte_addr;
  logic [7:0]      w_wbyte;
  logic [4:0]      w_cap_sh;
  logic [4:0]      w_last_sh;
  logic [31:0]     w_rd_cap;
  logic [31:0]     w_rd_last;
  logic [NPORT-1:0] w_onehot;

  function automatic logic [CW-1:0] size_to_n(input logic [1:0] s);
    case (s)
      2'd0:    return CW'(1);
      2'd1:    return CW'(2);
      default: return CW'(4);
    endcase
  endfunction

  function automatic logic io_hit(input logic [31:0] a);
    return IO_STALL && (a[17:16] == 2'b11);
  endfunction

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    assign w_addr_a[g]  = bus.req_addr[32*g +: 32];
    assign w_wdata_a[g] = bus.req_wdata[32*g +: 32];
    assign w_size_a[g]  = bus.req_size[2*g +: 2];
  end

  // Round-robin pick: first eligible port at or after r_ptr. The port whose
  // completion pulse is showing this cycle is excluded so it is never re-granted.
  always_comb begin
    logic [PW1-1:0] v_sum;
    v_sum  = '0;
    w_elig = bus.req_valid & ~bus.flush & ~r_resp_valid;
    w_gnt  = 1'b0;
    w_win  = '0;
    for (int k = 0; k < int'(NPORT); k++) begin
      v_sum = {1'b0, r_ptr} + PW1'(k);
      if (v_sum >= PW1'(NPORT)) begin
        v_sum = v_sum - PW1'(NPORT);
      end
      if (!w_gnt && w_elig[v_sum[PW-1:0]]) begin
        w_gnt = 1'b1;
        w_win = v_sum[PW-1:0];
      end
    end
  end

  assign w_ptr_next  = (w_win == PW'(NPORT - 1)) ? '0 : PW'(w_win + 1'b1);
  assign w_win_addr  = w_addr_a[w_win];
  assign w_win_wdata = w_wdata_a[w_win];
  assign w_win_we    = bus.req_we[w_win];
  assign w_win_n     = size_to_n(w_size_a[w_win]);
  assign w_stall_gnt = io_hit(w_win_addr) & bus.io_buffer_full;

  assign w_byte_addr = r_addr + 32'(r_cnt);
  assign w_stall_wr  = io_hit(w_byte_addr) & bus.io_buffer_full;
  assign w_wbyte     = 8'(r_wdata >> {r_cnt[1:0], 3'b000});

  // Byte cnt-2 is on mem_din while address cnt is out; the last byte lands in RDWAIT.
  assign w_cap_sh    = {2'(r_cnt - CW'(2)), 3'b000};
  assign w_last_sh   = {2'(r_n - CW'(1)), 3'b000};
  assign w_rd_cap    = r_rbuf | (32'(bus.mem_din) << w_cap_sh);
  assign w_rd_last   = r_rbuf | (32'(bus.mem_din) << w_last_sh);
  assign w_onehot    = NPORT'(1) << r_port;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_port       <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rbuf       <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else if (rdy) begin
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_port  <= w_win;
            r_ptr   <= w_ptr_next;
            r_n     <= w_win_n;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_rbuf  <= '0;
            if (w_win_we) begin
              r_state <= S_WR;
              if (w_stall_gnt) begin
                r_cnt <= '0;
              end else begin
                r_mem_a    <= w_win_addr;
                r_mem_dout <= w_win_wdata[7:0];
                r_mem_wr   <= 1'b1;
                r_cnt      <= CW'(1);
              end
            end else begin
              r_state <= S_RD;
              r_mem_a <= w_win_addr;
              r_cnt   <= CW'(1);
            end
          end
        end
        S_RD: begin
          if (bus.flush[r_port]) begin
            r_state <= S_IDLE;
            r_mem_a <= '0;
          end else begin
            if (r_cnt >= CW'(2)) begin
              r_rbuf <= w_rd_cap;
            end
            if (r_cnt == r_n) begin
              r_state <= S_RDWAIT;
              r_mem_a <= '0;
            end else begin
              r_mem_a <= w_byte_addr;
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        S_RDWAIT: begin
          r_state <= S_IDLE;
          if (!bus.flush[r_port]) begin
            r_resp_data  <= w_rd_last;
            r_resp_valid <= w_onehot;
          end
        end
        S_WR: begin
          // Writes always run to completion; flush is ignored here.
          if (r_cnt == r_n) begin
            r_state      <= S_IDLE;
            r_resp_valid <= w_onehot;
            r_mem_a      <= '0;
            r_mem_dout   <= '0;
            r_mem_wr     <= 1'b0;
          end else if (w_stall_wr) begin
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
          end else begin
            r_mem_a    <= w_byte_addr;
            r_mem_dout <= w_wbyte;
            r_mem_wr   <= 1'b1;
            r_cnt      <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_a      = r_mem_a;
  assign bus.mem_dout   = r_mem_dout;
  assign bus.mem_wr     = r_mem_wr & rdy;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide RAM model.
module tb_mem_arbiter;

  localparam int unsigned NPORT = 2;

  logic clk;
  logic rst;
  logic rdy;

  mem_arbiter_if #(.NPORT(NPORT)) bus();

  mem_arbiter #(.NPORT(NPORT), .IO_STALL(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: read data appears the cycle after its address; preloaded while in reset.
  logic [7:0]  ram [4096];
  int unsigned wr_count = 0;
  always @(posedge clk) begin
    if (!rst) begin
      ram[12'h000] <= 8'h00;
      ram[12'h100] <= 8'h13;
      ram[12'h101] <= 8'h12;
      ram[12'h102] <= 8'h11;
      ram[12'h103] <= 8'h10;
      bus.mem_din  <= 8'h00;
    end else begin
      bus.mem_din <= ram[bus.mem_a[11:0]];
      if (bus.mem_wr) begin
        ram[bus.mem_a[11:0]] <= bus.mem_dout;
        wr_count <= wr_count + 1;
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid[p]         = 1'b1;
    bus.req_we[p]            = we;
    bus.req_size[2*p +: 2]   = sz;
    bus.req_addr[32*p +: 32] = a;
    bus.req_wdata[32*p +: 32] = wd;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_mem_a"},  bus.mem_a, 32'h0);
    chk({tag, "_dout"},   32'(bus.mem_dout), 32'h0);
    chk({tag, "_wr"},     32'(bus.mem_wr), 32'h0);
    chk({tag, "_rv"},     32'(bus.resp_valid), 32'h0);
    chk({tag, "_rdata"},  bus.resp_data, 32'h0);
  endtask

  int          npulse;
  logic [31:0] prev_rv;
  int unsigned wc0;
  int unsigned wc_rst;

  initial begin
    rst                = 1'b0;
    rdy                = 1'b1;
    bus.req_valid      = '0;
    bus.req_we         = '0;
    bus.req_size       = '0;
    bus.req_addr       = '0;
    bus.req_wdata      = '0;
    bus.flush          = '0;
    bus.io_buffer_full = 1'b0;

    repeat (2) @(negedge clk);
    chk_zero_outs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Word read, port 0, at 0x100.
    set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 4) chk("rd_addr", bus.mem_a, 32'h100 + 32'(c - 1));
      else        chk("rd_addr_idle", bus.mem_a, 32'h0);
      chk("rd_wr", 32'(bus.mem_wr), 32'h0);
      chk("rd_rv", 32'(bus.resp_valid), (c == 6) ? 32'h1 : 32'h0);
      if (c == 6) begin
        chk("rd_data", bus.resp_data, 32'h10111213);
        bus.req_valid[0] = 1'b0;
      end
    end

    // Reset pulse to bring ptr back to 0; resp_data must clear.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_rdata", bus.resp_data, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Both ports request byte reads continuously: grants alternate 0,1,0,1.
    set_req(0, 1'b0, 2'd0, 32'h100, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h101, 32'h0);
    npulse  = 0;
    prev_rv = 32'h0;
    for (int c = 0; c < 40 && npulse < 4; c++) begin
      @(negedge clk);
      if (bus.resp_valid != '0) begin
        chk("alt_port",  32'(bus.resp_valid), (npulse % 2 == 0) ? 32'h1 : 32'h2);
        chk("alt_data",  bus.resp_data, (npulse % 2 == 0) ? 32'h13 : 32'h12);
        chk("alt_width", prev_rv, 32'h0);
        npulse++;
        if (npulse == 4) bus.req_valid = '0;
      end
      prev_rv = 32'(bus.resp_valid);
    end
    chk("alt_count", 32'(npulse), 32'd4);
    @(negedge clk);
    chk("alt_tail", 32'(bus.resp_valid), 32'h0);
    @(negedge clk);

    // Port 1 IO byte write with io_buffer_full high for 3 cycles.
    set_req(1, 1'b1, 2'd0, 32'h30000, 32'h41);
    bus.io_buffer_full = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk("io_wr", 32'(bus.mem_wr), (c == 4) ? 32'h1 : 32'h0);
      chk("io_a",  bus.mem_a, (c == 4) ? 32'h30000 : 32'h0);
      if (c == 4) chk("io_dout", 32'(bus.mem_dout), 32'h41);
      chk("io_rv", 32'(bus.resp_valid), (c == 5) ? 32'h2 : 32'h0);
      if (c == 3) bus.io_buffer_full = 1'b0;
    end
    bus.req_valid[1] = 1'b0;
    @(negedge clk);

    // Port 0 word read flushed in cycle 3; pending port 1 byte read follows.
    set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_req(1, 1'b0, 2'd0, 32'h102, 32'h0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      chk("fl_rv", 32'(bus.resp_valid), (c == 7) ? 32'h2 : 32'h0);
      if (c == 3) begin
        chk("fl_a3", bus.mem_a, 32'h102);
        bus.flush[0] = 1'b1;
      end
      if (c == 4) begin
        chk("fl_idle_a", bus.mem_a, 32'h0);
        chk("fl_rdata_kept", bus.resp_data, 32'h12);
        bus.flush[0]     = 1'b0;
        bus.req_valid[0] = 1'b0;
      end
      if (c == 5) chk("fl_p1_a", bus.mem_a, 32'h102);
      if (c == 7) begin
        chk("fl_p1_data", bus.resp_data, 32'h11);
        bus.req_valid[1] = 1'b0;
      end
    end
    @(negedge clk);

    // Half read at 0x102 with rdy low for the two cycles after the first address.
    set_req(0, 1'b0, 2'd1, 32'h102, 32'h0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("rdy_wr", 32'(bus.mem_wr), 32'h0);
      chk("rdy_rv", 32'(bus.resp_valid), (c == 6) ? 32'h1 : 32'h0);
      if (c <= 3) chk("rdy_a_hold", bus.mem_a, 32'h102);
      if (c == 4) chk("rdy_a2", bus.mem_a, 32'h103);
      if (c == 1) rdy = 1'b0;
      if (c == 3) rdy = 1'b1;
      if (c == 6) begin
        chk("rdy_data", bus.resp_data, 32'h1011);
        bus.req_valid[0] = 1'b0;
      end
    end
    @(negedge clk);

    // Half write with rdy dropped while byte 0 is on the bus.
    wc0 = wr_count;
    set_req(0, 1'b1, 2'd1, 32'h200, 32'h1234BEEF);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("wrdy_rv", 32'(bus.resp_valid), (c == 4) ? 32'h1 : 32'h0);
      if (c == 1) begin
        chk("wrdy_wr1", 32'(bus.mem_wr), 32'h1);
        rdy = 1'b0;
        #1;
        chk("wrdy_gate", 32'(bus.mem_wr), 32'h0);
      end
      if (c == 2) begin
        chk("wrdy_hold_a", bus.mem_a, 32'h200);
        chk("wrdy_wr2", 32'(bus.mem_wr), 32'h0);
        rdy = 1'b1;
        #1;
        chk("wrdy_dout0", 32'(bus.mem_dout), 32'hEF);
        chk("wrdy_wr_resume", 32'(bus.mem_wr), 32'h1);
      end
      if (c == 3) begin
        chk("wrdy_a1", bus.mem_a, 32'h201);
        chk("wrdy_dout1", 32'(bus.mem_dout), 32'hBE);
      end
      if (c == 4) bus.req_valid[0] = 1'b0;
    end
    chk("wrdy_count", wr_count - wc0, 32'd2);
    chk("wrdy_ram0", 32'(ram[12'h200]), 32'hEF);
    chk("wrdy_ram1", 32'(ram[12'h201]), 32'hBE);
    @(negedge clk);

    // Port 1 word write interrupted by reset in cycle 2.
    wc0 = wr_count;
    set_req(1, 1'b1, 2'd2, 32'h300, 32'hA1B2C3D4);
    @(negedge clk);
    chk("rw_a0",    bus.mem_a, 32'h300);
    chk("rw_dout0", 32'(bus.mem_dout), 32'hD4);
    chk("rw_wr0",   32'(bus.mem_wr), 32'h1);
    @(negedge clk);
    chk("rw_a1",    bus.mem_a, 32'h301);
    chk("rw_dout1", 32'(bus.mem_dout), 32'hC3);
    rst = 1'b0;
    bus.req_valid[1] = 1'b0;
    #1;
    chk_zero_outs("async_rst");
    wc_rst = wr_count;
    chk("rw_pre_count", wc_rst - wc0, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_wr", 32'(bus.mem_wr), 32'h0);
      chk("post_rst_a",  bus.mem_a, 32'h0);
    end
    chk("post_rst_count", wr_count, wc_rst);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
